// File: rtl/lsu_sram_resp.sv
// lsu_sram_resp: handshaked load/store responder with one outstanding access in front of pmem_read/pmem_write.
// Optional macro SRAM_RAND_DELAY_EN adds 0..3 LFSR-chosen cycles to every access latency.

package lsu_sram_resp_pmem_pkg;
  // Byte-addressed behavioural memory behind the pmem hooks, plus call bookkeeping.
  logic [7:0]  pmem_mem [logic [31:0]];
  int unsigned pmem_rd_cnt;
  int unsigned pmem_wr_cnt;
  logic [31:0] pmem_last_raddr;
  logic [31:0] pmem_last_waddr;
  logic [2:0]  pmem_last_wlen;
  logic [31:0] pmem_last_wdata;

  function automatic logic [31:0] pmem_read(input logic [31:0] raddr, input logic [2:0] len);
    logic [31:0] d;
    d = 32'h0000_0000;
    for (int i = 32'sd0; i < 32'sd4; i++) begin
      if (i < int'(len)) d[8*i +: 8] = pmem_mem[raddr + 32'(i)];
    end
    pmem_rd_cnt     = pmem_rd_cnt + 32'd1;
    pmem_last_raddr = raddr;
    return d;
  endfunction

  function automatic void pmem_write(input logic [31:0] waddr, input logic [2:0] len,
                                     input logic [31:0] wdata);
    for (int i = 32'sd0; i < 32'sd4; i++) begin
      if (i < int'(len)) pmem_mem[waddr + 32'(i)] = wdata[8*i +: 8];
    end
    pmem_wr_cnt     = pmem_wr_cnt + 32'd1;
    pmem_last_waddr = waddr;
    pmem_last_wlen  = len;
    pmem_last_wdata = wdata;
  endfunction
endpackage

module lsu_sram_resp
  import lsu_sram_resp_pmem_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int WR_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        awready,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP} state_t;

  localparam logic [4:0] RD_BASE = 5'(RD_LAT - 1);
  localparam logic [4:0] WR_BASE = 5'(WR_LAT - 1);

  state_t      state_r, state_nxt_s;
  logic [4:0]  cnt_r, rd_load_s, wr_load_s;
  logic [29:0] addr_r;
  logic [31:0] wdata_r, rdata_r;
  logic [3:0]  strb_r;
  logic [1:0]  rresp_r, bresp_r;
  logic        rvalid_r, bvalid_r;
  logic        rd_acc_s, wr_acc_s;
  logic        unused_s;

  // Word-aligned accesses only; the LSU handles sub-word extraction.
  assign unused_s = ^{araddr[1:0], awaddr[1:0]};

`ifdef SRAM_RAND_DELAY_EN
  logic [3:0] lfsr_r;

  // Free-running LFSR supplying 0..3 extra wait cycles per access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_r <= 4'b1011;
    else        lfsr_r <= {lfsr_r[2:0], lfsr_r[3] ^ lfsr_r[2]};
  end

  assign rd_load_s = RD_BASE + {3'b000, lfsr_r[1:0]};
  assign wr_load_s = WR_BASE + {3'b000, lfsr_r[1:0]};
`else
  assign rd_load_s = RD_BASE;
  assign wr_load_s = WR_BASE;
`endif

  assign arready = rst_n && (state_r == IDLE);
  assign awready = rst_n && (state_r == IDLE) && !arvalid && awvalid && wvalid;
  assign wready  = awready;
  assign rdata   = rdata_r;
  assign rresp   = rresp_r;
  assign rvalid  = rvalid_r;
  assign bresp   = bresp_r;
  assign bvalid  = bvalid_r;

  // Next-state logic; a read wins over a simultaneous write request.
  always_comb begin
    state_nxt_s = state_r;
    rd_acc_s    = 1'b0;
    wr_acc_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (arvalid) begin
          rd_acc_s    = 1'b1;
          state_nxt_s = RD_WAIT;
        end else if (awvalid && wvalid) begin
          wr_acc_s    = 1'b1;
          state_nxt_s = WR_WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD_WAIT: if (cnt_r == 5'd0) state_nxt_s = RD_RESP; else state_nxt_s = RD_WAIT;
      RD_RESP: if (rready)        state_nxt_s = IDLE;    else state_nxt_s = RD_RESP;
      WR_WAIT: if (cnt_r == 5'd0) state_nxt_s = WR_RESP; else state_nxt_s = WR_WAIT;
      WR_RESP: if (bready)        state_nxt_s = IDLE;    else state_nxt_s = WR_RESP;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, request capture, latency count, memory access and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= 5'd0;
      addr_r   <= 30'd0;
      wdata_r  <= 32'd0;
      strb_r   <= 4'd0;
      rdata_r  <= 32'd0;
      rresp_r  <= 2'b00;
      bresp_r  <= 2'b00;
      rvalid_r <= 1'b0;
      bvalid_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        IDLE: begin
          if (rd_acc_s) begin
            addr_r <= araddr[31:2];
            cnt_r  <= rd_load_s;
          end else if (wr_acc_s) begin
            addr_r  <= awaddr[31:2];
            wdata_r <= wdata;
            strb_r  <= wstrb;
            cnt_r   <= wr_load_s;
          end
        end
        RD_WAIT: begin
          if (cnt_r != 5'd0) begin
            cnt_r <= cnt_r - 5'd1;
          end else begin
            rdata_r  <= pmem_read({addr_r, 2'b00}, 3'd4);
            rresp_r  <= 2'b00;
            rvalid_r <= 1'b1;
          end
        end
        RD_RESP: if (rready) rvalid_r <= 1'b0;
        WR_WAIT: begin
          if (cnt_r != 5'd0) begin
            cnt_r <= cnt_r - 5'd1;
          end else begin
            bvalid_r <= 1'b1;
            bresp_r  <= 2'b00;
            // Only naturally aligned byte, halfword and word strobes are legal.
            case (strb_r)
              4'b0001: pmem_write({addr_r, 2'b00}, 3'd1, wdata_r);
              4'b0010: pmem_write({addr_r, 2'b01}, 3'd1, wdata_r >> 8'd8);
              4'b0100: pmem_write({addr_r, 2'b10}, 3'd1, wdata_r >> 8'd16);
              4'b1000: pmem_write({addr_r, 2'b11}, 3'd1, wdata_r >> 8'd24);
              4'b0011: pmem_write({addr_r, 2'b00}, 3'd2, wdata_r);
              4'b1100: pmem_write({addr_r, 2'b10}, 3'd2, wdata_r >> 8'd16);
              4'b1111: pmem_write({addr_r, 2'b00}, 3'd4, wdata_r);
              default: bresp_r <= 2'b10;
            endcase
          end
        end
        WR_RESP: if (bready) bvalid_r <= 1'b0;
        default: cnt_r <= 5'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_sram_resp.sv
// Directed bench for lsu_sram_resp: a fast instance (RD_LAT=1, WR_LAT=1) and a slow one (RD_LAT=3, WR_LAT=4).
module tb_lsu_sram_resp;
  import lsu_sram_resp_pmem_pkg::*;

`ifdef SRAM_RAND_DELAY_EN
  localparam int XTRA = 3;
`else
  localparam int XTRA = 0;
`endif

  localparam logic [3:0]  T_STRB [0:10] = '{4'b0010, 4'b0101, 4'b0001, 4'b1000, 4'b0100, 4'b0011,
                                            4'b1100, 4'b1111, 4'b0000, 4'b1110, 4'b0110};
  localparam logic [31:0] T_DATA [0:10] = '{32'h0000AB00, 32'h12345678, 32'h000000C1, 32'h7F000000,
                                            32'h00EE0000, 32'h0000BEAD, 32'hCAFE0000, 32'h01020304,
                                            32'hFFFFFFFF, 32'h55667788, 32'h99AABBCC};
  localparam logic [31:0] T_ADDR [0:10] = '{32'h80000021, 32'h0, 32'h80000020, 32'h80000023,
                                            32'h80000022, 32'h80000020, 32'h80000022, 32'h80000020,
                                            32'h0, 32'h0, 32'h0};
  localparam logic [2:0]  T_LEN  [0:10] = '{3'd1, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd4, 3'd0, 3'd0, 3'd0};
  localparam logic [31:0] T_WD   [0:10] = '{32'hAB, 32'h0, 32'hC1, 32'h7F, 32'hEE, 32'hBEAD, 32'hCAFE,
                                            32'h01020304, 32'h0, 32'h0, 32'h0};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [31:0] araddr, awaddr, wdata;
  logic [3:0]  wstrb;
  logic        rready, bready;
  logic [1:0]  arvalid, awvalid, wvalid, arready, rvalid, awready, wready, bvalid;
  logic [1:0][31:0] rdata;
  logic [1:0][1:0]  rresp, bresp;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  lsu_sram_resp #(.RD_LAT(1), .WR_LAT(1)) u_fast (
    .clk(clk), .rst_n(rst_n), .araddr(araddr), .arvalid(arvalid[0]), .arready(arready[0]),
    .rdata(rdata[0]), .rresp(rresp[0]), .rvalid(rvalid[0]), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid[0]), .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid[0]),
    .awready(awready[0]), .wready(wready[0]), .bresp(bresp[0]), .bvalid(bvalid[0]), .bready(bready));

  lsu_sram_resp #(.RD_LAT(3), .WR_LAT(4)) u_slow (
    .clk(clk), .rst_n(rst_n), .araddr(araddr), .arvalid(arvalid[1]), .arready(arready[1]),
    .rdata(rdata[1]), .rresp(rresp[1]), .rvalid(rvalid[1]), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid[1]), .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid[1]),
    .awready(awready[1]), .wready(wready[1]), .bresp(bresp[1]), .bvalid(bvalid[1]), .bready(bready));

  task automatic do_read(input int d, input logic [31:0] a, output logic seen,
                         output logic [31:0] data, output logic [1:0] resp, output int lat);
    @(negedge clk);
    araddr = a; arvalid[d] = 1'b1; rready = 1'b1;
    #1 seen = arready[d];
    @(negedge clk);
    arvalid[d] = 1'b0; lat = 0;
    while (rvalid[d] !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    if (rvalid[d] !== 1'b1) lat = -1;
    data = rdata[d]; resp = rresp[d];
  endtask

  task automatic do_write(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                          output logic seen, output logic [1:0] resp, output int lat);
    @(negedge clk);
    awaddr = a; wdata = wd; wstrb = st; awvalid[d] = 1'b1; wvalid[d] = 1'b1; bready = 1'b1;
    #1 seen = awready[d] & wready[d];
    @(negedge clk);
    awvalid[d] = 1'b0; wvalid[d] = 1'b0; lat = 0;
    while (bvalid[d] !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    if (bvalid[d] !== 1'b1) lat = -1;
    resp = bresp[d];
  endtask

  task automatic test_reset();
    arvalid = 2'b11; awvalid = 2'b11; wvalid = 2'b11;
    #2 rst_n = 1'b0;
    #10;
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({arready[d], awready[d], wready[d], rvalid[d], bvalid[d], rdata[d], rresp[d], bresp[d]} !== 41'd0) begin
        bad++;
        $display("FAIL reset_outputs[%0d] got ar=%b aw=%b w=%b rv=%b bv=%b rd=%h rr=%b br=%b exp all zero",
                 d, arready[d], awready[d], wready[d], rvalid[d], bvalid[d], rdata[d], rresp[d], bresp[d]);
      end
    end
    arvalid = 2'b00; awvalid = 2'b00; wvalid = 2'b00;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (arready !== 2'b11) begin bad++; $display("FAIL reset_release_arready got=%b exp=11", arready); end
  endtask

  task automatic test_read_basic();
    logic seen; logic [1:0] resp; logic [31:0] data; int lat; int unsigned c0;
    c0 = pmem_wr_cnt;
    do_write(0, 32'h80000010, 32'hDEADBEEF, 4'b1111, seen, resp, lat);
    total++; if (resp !== 2'b00 || seen !== 1'b1) begin bad++; $display("FAIL preload_write got resp=%b seen=%b exp 00/1", resp, seen); end
    total++; if (lat < 1 || lat > 1 + XTRA) begin bad++; $display("FAIL wr_latency got=%0d exp=1..%0d", lat, 1 + XTRA); end
    total++; if (pmem_wr_cnt - c0 !== 32'd1) begin bad++; $display("FAIL preload_wr_calls got=%0d exp=1", pmem_wr_cnt - c0); end
    c0 = pmem_rd_cnt;
    do_read(0, 32'h80000012, seen, data, resp, lat);
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL rd_arready got=%b exp=1", seen); end
    total++; if (lat < 1 || lat > 1 + XTRA) begin bad++; $display("FAIL rd_latency got=%0d exp=1..%0d", lat, 1 + XTRA); end
    total++; if (data !== 32'hDEADBEEF || resp !== 2'b00) begin bad++; $display("FAIL rd_data got=%h/%b exp=deadbeef/00", data, resp); end
    total++; if (pmem_rd_cnt - c0 !== 32'd1) begin bad++; $display("FAIL rd_calls got=%0d exp=1", pmem_rd_cnt - c0); end
    total++; if (pmem_last_raddr !== 32'h80000010) begin bad++; $display("FAIL rd_addr got=%h exp=80000010", pmem_last_raddr); end
  endtask

  task automatic test_read_hold();
    logic seen; logic [1:0] resp; int lat;
    do_write(0, 32'h80000014, 32'h12345678, 4'b1111, seen, resp, lat);
    total++; if (resp !== 2'b00) begin bad++; $display("FAIL hold_preload got=%b exp=00", resp); end
    @(negedge clk);
    araddr = 32'h80000016; arvalid[1] = 1'b1; rready = 1'b0;
    @(negedge clk);
    arvalid[1] = 1'b0; lat = 0;
    while (rvalid[1] !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    total++; if (lat < 3 || lat > 3 + XTRA) begin bad++; $display("FAIL slow_rd_latency got=%0d exp=3..%0d", lat, 3 + XTRA); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if ({rvalid[1], arready[1], rdata[1], rresp[1]} !== {1'b1, 1'b0, 32'h12345678, 2'b00}) begin
        bad++;
        $display("FAIL rd_hold[%0d] got rv=%b ar=%b rd=%h rr=%b exp 1/0/12345678/00", k, rvalid[1], arready[1], rdata[1], rresp[1]);
      end
    end
    rready = 1'b1;
    @(negedge clk);
    total++; if (rvalid[1] !== 1'b0 || arready[1] !== 1'b1) begin bad++; $display("FAIL rd_release got rv=%b ar=%b exp 0/1", rvalid[1], arready[1]); end
  endtask

  task automatic test_write_strobes();
    logic seen; logic [1:0] resp; int lat; int unsigned c0;
    logic [31:0] ea, ed; logic [2:0] el; logic ok;
    for (int i = 0; i < 11; i++) begin
      ea = T_ADDR[i]; ed = T_WD[i]; el = T_LEN[i]; ok = (el != 3'd0);
      c0 = pmem_wr_cnt;
      do_write(0, 32'h80000020 + 32'(i % 4), T_DATA[i], T_STRB[i], seen, resp, lat);
      total++; if (resp !== (ok ? 2'b00 : 2'b10)) begin bad++; $display("FAIL wstrb_resp[%b] got=%b exp=%b", T_STRB[i], resp, ok ? 2'b00 : 2'b10); end
      total++; if (pmem_wr_cnt - c0 !== (ok ? 32'd1 : 32'd0)) begin bad++; $display("FAIL wstrb_calls[%b] got=%0d exp=%0d", T_STRB[i], pmem_wr_cnt - c0, ok); end
      if (ok) begin
        total++;
        if ({pmem_last_waddr, pmem_last_wlen, pmem_last_wdata} !== {ea, el, ed}) begin
          bad++;
          $display("FAIL wstrb_args[%b] got=%h,%0d,%h exp=%h,%0d,%h", T_STRB[i], pmem_last_waddr, pmem_last_wlen, pmem_last_wdata, ea, el, ed);
        end
        total++; if (pmem_mem[ea] !== ed[7:0]) begin bad++; $display("FAIL wstrb_mem[%b] got=%h exp=%h", T_STRB[i], pmem_mem[ea], ed[7:0]); end
      end
    end
  endtask

  task automatic test_collision();
    int n; logic aw_hi; int unsigned w0, r0;
    w0 = pmem_wr_cnt; r0 = pmem_rd_cnt;
    @(negedge clk);
    araddr = 32'h80000010; arvalid[0] = 1'b1; rready = 1'b0; bready = 1'b1;
    awaddr = 32'h80000030; wdata = 32'h11223344; wstrb = 4'b1111; awvalid[0] = 1'b1; wvalid[0] = 1'b1;
    #1;
    total++; if ({arready[0], awready[0], wready[0]} !== 3'b100) begin bad++; $display("FAIL coll_ready got=%b exp=100", {arready[0], awready[0], wready[0]}); end
    @(negedge clk);
    arvalid[0] = 1'b0; n = 0; aw_hi = awready[0] | wready[0];
    while (rvalid[0] !== 1'b1 && n < 40) begin @(negedge clk); n++; aw_hi |= awready[0] | wready[0]; end
    @(negedge clk); aw_hi |= awready[0] | wready[0];
    total++; if (aw_hi !== 1'b0) begin bad++; $display("FAIL coll_aw_blocked got=%b exp=0", aw_hi); end
    total++; if (rvalid[0] !== 1'b1 || rdata[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL coll_rdata got=%b/%h exp=1/deadbeef", rvalid[0], rdata[0]); end
    total++; if (pmem_wr_cnt - w0 !== 32'd0) begin bad++; $display("FAIL coll_early_write got=%0d exp=0", pmem_wr_cnt - w0); end
    rready = 1'b1;
    @(negedge clk);
    total++; if (awready[0] !== 1'b1) begin bad++; $display("FAIL coll_aw_after got=%b exp=1", awready[0]); end
    @(negedge clk);
    awvalid[0] = 1'b0; wvalid[0] = 1'b0; n = 0;
    while (bvalid[0] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    total++; if (bvalid[0] !== 1'b1 || bresp[0] !== 2'b00) begin bad++; $display("FAIL coll_bresp got=%b/%b exp=1/00", bvalid[0], bresp[0]); end
    total++;
    if ({pmem_last_waddr, pmem_last_wdata} !== {32'h80000030, 32'h11223344} || pmem_wr_cnt - w0 !== 32'd1 || pmem_rd_cnt - r0 !== 32'd1) begin
      bad++;
      $display("FAIL coll_write got=%h,%h wr=%0d rd=%0d exp=80000030,11223344 wr=1 rd=1", pmem_last_waddr, pmem_last_wdata, pmem_wr_cnt - w0, pmem_rd_cnt - r0);
    end
  endtask

  task automatic test_reset_mid();
    logic seen; logic [1:0] resp; logic [31:0] data; int lat; int unsigned w0;
    w0 = pmem_wr_cnt;
    @(negedge clk);
    awaddr = 32'h80000040; wdata = 32'hA5A5A5A5; wstrb = 4'b1111; awvalid[1] = 1'b1; wvalid[1] = 1'b1; bready = 1'b1;
    @(negedge clk);
    awvalid[1] = 1'b0; wvalid[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if ({bvalid[1], awready[1], arready[1]} !== 3'b000) begin bad++; $display("FAIL mid_reset_out got=%b exp=000", {bvalid[1], awready[1], arready[1]}); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (pmem_wr_cnt - w0 !== 32'd0 || pmem_mem.exists(32'h80000040)) begin bad++; $display("FAIL mid_reset_dropped got calls=%0d exp=0", pmem_wr_cnt - w0); end
    total++; if (bvalid[1] !== 1'b0 || arready[1] !== 1'b1) begin bad++; $display("FAIL mid_reset_idle got bv=%b ar=%b exp 0/1", bvalid[1], arready[1]); end
    do_read(1, 32'h80000010, seen, data, resp, lat);
    total++; if (data !== 32'hDEADBEEF || lat < 3 || lat > 3 + XTRA) begin bad++; $display("FAIL mid_reset_read got=%h lat=%0d exp=deadbeef lat=3..%0d", data, lat, 3 + XTRA); end
  endtask

  task automatic test_back_to_back();
    logic seen; logic [1:0] resp; logic [31:0] data, exp_d; int lat; int unsigned c0;
    for (int i = 0; i < 64; i++) begin
      exp_d = (i % 2 == 0) ? 32'hDEADBEEF : 32'h12345678;
      c0 = pmem_rd_cnt;
      do_read(0, (i % 2 == 0) ? 32'h80000011 : 32'h80000017, seen, data, resp, lat);
      total++; if (lat < 1 || lat > 1 + XTRA) begin bad++; $display("FAIL b2b_latency[%0d] got=%0d exp=1..%0d", i, lat, 1 + XTRA); end
      total++; if (data !== exp_d || resp !== 2'b00) begin bad++; $display("FAIL b2b_data[%0d] got=%h/%b exp=%h/00", i, data, resp, exp_d); end
      total++; if (pmem_rd_cnt - c0 !== 32'd1) begin bad++; $display("FAIL b2b_calls[%0d] got=%0d exp=1", i, pmem_rd_cnt - c0); end
    end
  endtask

  initial begin
    araddr = 32'd0; awaddr = 32'd0; wdata = 32'd0; wstrb = 4'd0; rready = 1'b0; bready = 1'b0;
    arvalid = 2'b00; awvalid = 2'b00; wvalid = 2'b00;
    test_reset();
    test_read_basic();
    test_read_hold();
    test_write_strobes();
    test_collision();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_sram_resp.md
Name: lsu_sram_resp

Overview:
- Memory-side responder for load/store requests issued by the execute stage's data-memory port.
- Accepts AXI4-Lite-style read and write requests on valid/ready channels and waits a programmable latency.
- Performs the access through the DPI functions pmem_read(raddr, len) and pmem_write(waddr, len, wdata), then returns a response.
- Replaces the single-cycle clock-edge DPI calls on the data side with a handshaked, multi-cycle responder.

Parameters:
- RD_LAT, 1: cycles from read acceptance edge to rvalid rising; legal range 1..15.
- WR_LAT, 1: cycles from write acceptance edge to bvalid rising; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- araddr  in  32  read address.
- arvalid  in  1  read request valid.
- arready  out  1  read request accepted.
- rdata  out  32  read data, always the full aligned word.
- rresp  out  2  read response; 2'b00 means OKAY.
- rvalid  out  1  read response valid.
- rready  in  1  read response accepted.
- awaddr  in  32  write address.
- awvalid  in  1  write address valid.
- wdata  in  32  write data, lane-aligned.
- wstrb  in  4  byte-lane write strobes.
- wvalid  in  1  write data valid.
- awready  out  1  write address accepted.
- wready  out  1  write data accepted.
- bresp  out  2  write response; 2'b00 OKAY, 2'b10 SLVERR.
- bvalid  out  1  write response valid.
- bready  in  1  write response accepted.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - arready, awready, wready, rvalid, bvalid = 0; rdata = 0; rresp = bresp = 2'b00; latency counter = 0.
  - arready, awready and wready are forced to 0 while rst_n is low.
- Ordering: one outstanding transaction total. States are IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP.
- Ready signals (combinational from state and inputs):
  - arready = (state==IDLE).
  - awready = wready = (state==IDLE) && !arvalid && awvalid && wvalid.
  - Address and data are accepted together only. Read has priority when both channels request in the same cycle.
- Read acceptance: on an edge with arvalid && arready:
  - Capture araddr[31:2].
  - Load counter with RD_LAT-1.
  - Go to RD_WAIT.
- RD_WAIT:
  - If the counter is nonzero, decrement it.
  - If the counter is 0, at that edge call pmem_read({addr_q,2'b00}, 4), register the result into rdata, set rresp=00 and rvalid=1, and go to RD_RESP.
  - Net effect: rvalid is high RD_LAT cycles after the acceptance edge.
- RD_RESP:
  - rdata and rresp are held stable while rvalid && !rready.
  - On an edge with rready, clear rvalid and go to IDLE.
  - A new request can be accepted in the cycle after that (no back-to-back overlap).
- Write acceptance: capture awaddr[31:2], wdata and wstrb; load counter with WR_LAT-1; go to WR_WAIT.
- WR_WAIT: at counter 0, decode wstrb and set bvalid=1; go to WR_RESP.
  - 0001, 0010, 0100, 1000: pmem_write(base+k, 1, wdata>>(8k)), k = lane index.
  - 0011: pmem_write(base, 2, wdata).
  - 1100: pmem_write(base+2, 2, wdata>>16).
  - 1111: pmem_write(base, 4, wdata).
  - Any other value, including 0000: no DPI call, bresp=2'b10.
  - All legal patterns give bresp=2'b00.
- WR_RESP: hold bresp and bvalid until bready; then go to IDLE.
- Exactly one DPI call per accepted transaction, and none for an SLVERR write.
- araddr[1:0] and awaddr[1:0] are ignored. The LSU extracts bytes and halfwords and sign-extends them.
- Reset mid-transaction:
  - A pending access whose DPI call has not yet happened is dropped and never issued.
  - An already-issued write remains committed.
  - Outputs return to reset values immediately.
- Inputs on a channel are don't-care whenever that channel's valid is low.

Optional Feature:
- Macro: SRAM_RAND_DELAY_EN.
- Defined:
  - A 4-bit Fibonacci LFSR (taps bits 3 and 2, reset seed 4'b1011) advances every cycle.
  - At each acceptance, the counter is loaded with LAT-1+lfsr[1:0], adding 0..3 extra cycles. All other rules are unchanged.
- Undefined: no LFSR is present and latency is exactly RD_LAT/WR_LAT.

Test Plan:
- RD_LAT=1; memory word 0x80000010=0xDEADBEEF; arvalid with araddr=0x80000012, rready=1 -> arready=1 in the request cycle; rvalid high on the next cycle with rdata=0xDEADBEEF, rresp=00; exactly one pmem_read(0x80000010,4).
- RD_LAT=3; rready held 0 for 5 cycles -> rvalid rises 3 cycles after acceptance; rdata stays stable and arready stays 0 until the rready edge.
- Write awaddr=0x80000020, wdata=0x0000AB00, wstrb=0010 -> pmem_write(0x80000021,1,0xAB); bresp=00. Then wstrb=0101 -> no DPI write, bresp=10.
- arvalid and awvalid/wvalid asserted in the same cycle -> read accepted first; awready=0 until the read completes; the write is accepted afterwards with its data unchanged.
- WR_LAT=4; rst_n dropped 2 cycles after write acceptance -> no pmem_write call; bvalid=0; after release, arready=1 and a fresh read completes normally.
- With SRAM_RAND_DELAY_EN, 64 back-to-back reads -> every latency is in RD_LAT..RD_LAT+3; data is always correct; one DPI call per read.
